// File: rtl/affine_ctrl_pkg.sv
// Shared types for the affine loop controller and the unified-buffer port modules.
package affine_ctrl_pkg;

  localparam int unsigned W_DEF        = 16;
  localparam int unsigned NUM_DIMS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [NUM_DIMS_DEF-1:0][W_DEF-1:0] ctrl_vars_t;

endpackage

// File: rtl/affine_odometer.sv
// Iteration-point registers for the affine loop controller: odometer carry chain
// (index 0 outermost) and last-point detect. An extent of 0 behaves as 1.
module affine_odometer #(
  parameter int unsigned NUM_DIMS = 3,
  parameter int unsigned W        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         adv_i,
  input  logic [NUM_DIMS-1:0][W-1:0]   extent_i,
  output logic [NUM_DIMS-1:0][W-1:0]   vars_o,
  output logic                         last_o
);

  logic [NUM_DIMS-1:0][W-1:0] vars_q, vars_d;
  logic [NUM_DIMS-1:0]        at_max;
  logic                       carry;

  always_comb begin
    at_max = '0;
    for (int unsigned k = 0; k < NUM_DIMS; k++) begin
      if (extent_i[k] == '0) at_max[k] = (vars_q[k] == '0);
      else                   at_max[k] = (vars_q[k] == extent_i[k] - W'(1));
    end
  end

  assign last_o = &at_max;

  // Carry ripples from the innermost dimension outward; the last point holds.
  always_comb begin
    vars_d = vars_q;
    carry  = adv_i & ~last_o;
    for (int unsigned k = 0; k < NUM_DIMS; k++) begin
      if (carry) begin
        if (at_max[NUM_DIMS-1-k]) begin
          vars_d[NUM_DIMS-1-k] = '0;
        end else begin
          vars_d[NUM_DIMS-1-k] = vars_q[NUM_DIMS-1-k] + W'(1);
          carry = 1'b0;
        end
      end
    end
    if (clr_i) vars_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vars_q <= '0;
    else     vars_q <= vars_d;
  end

  assign vars_o = vars_q;

endmodule

// File: rtl/affine_loop_ctrl.sv
// Affine-schedule loop controller: fires valid when cycle_cnt reaches
// offset + sum(coef*vars). Define AFFINE_LOOP_CTRL_CHECK_EN for the missed-schedule check.
module affine_loop_ctrl
  import affine_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIMS = NUM_DIMS_DEF,
  parameter int unsigned W        = W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         start,
  input  logic [NUM_DIMS-1:0][W-1:0]   extent,
  input  logic [NUM_DIMS-1:0][W-1:0]   coef,
  input  logic [W-1:0]                 offset,
  output logic                         valid,
  output logic [NUM_DIMS-1:0][W-1:0]   ctrl_vars,
  output logic                         done,
  output logic                         sched_err
);

  state_e                     state_q, state_d;
  logic [W-1:0]               cnt_q, cnt_d;
  logic [W-1:0]               target;
  logic [NUM_DIMS-1:0][W-1:0] vars;
  logic                       last;
  logic                       clr;

  affine_odometer #(
    .NUM_DIMS (NUM_DIMS),
    .W        (W)
  ) u_odometer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .adv_i    (valid),
    .extent_i (extent),
    .vars_o   (vars),
    .last_o   (last)
  );

  always_comb begin
    target = offset;
    for (int unsigned k = 0; k < NUM_DIMS; k++) begin
      target = target + coef[k] * vars[k];
    end
  end

  assign valid     = (state_q == RUN) && (cnt_q == target);
  assign done      = (state_q == DONE);
  assign ctrl_vars = vars;

`ifdef AFFINE_LOOP_CTRL_CHECK_EN
  logic err_q, err_d;
  logic miss;

  assign miss      = (state_q == RUN) && (target < cnt_q);
  assign sched_err = err_q | miss;

  always_comb begin
    err_d = err_q;
    if (flush || ((state_q != RUN) && start)) err_d = 1'b0;
    else if (miss)                            err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign sched_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            clr     = 1'b1;
          end
        end
        RUN: begin
          cnt_d = cnt_q + W'(1);
          if (valid && last) state_d = DONE;
`ifdef AFFINE_LOOP_CTRL_CHECK_EN
          if (miss) state_d = DONE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_affine_loop_ctrl.sv
// Directed scoreboard bench for affine_loop_ctrl; the sched_err scenario
// depends on whether AFFINE_LOOP_CTRL_CHECK_EN is defined.
module tb_affine_loop_ctrl;
  import affine_ctrl_pkg::*;

  typedef struct {
    int         cyc;
    ctrl_vars_t v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, flush, start;
  ctrl_vars_t ext, cf, cv;
  logic [W_DEF-1:0] offset;
  logic       valid, done, sched_err;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  affine_loop_ctrl #(
    .NUM_DIMS (NUM_DIMS_DEF),
    .W        (W_DEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .extent    (ext),
    .coef      (cf),
    .offset    (offset),
    .valid     (valid),
    .ctrl_vars (cv),
    .done      (done),
    .sched_err (sched_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_vars_t pt(input int a, input int b, input int c);
    ctrl_vars_t v;
    v[0] = W_DEF'(a);
    v[1] = W_DEF'(b);
    v[2] = W_DEF'(c);
    return v;
  endfunction

  task automatic push(input int cyc, input int a, input int b, input int c);
    exp_t e;
    e.cyc = cyc;
    e.v   = pt(a, b, c);
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic config_run(input ctrl_vars_t e, input ctrl_vars_t c, input int off);
    ext    = e;
    cf     = c;
    offset = W_DEF'(off);
  endtask

  // Leaves the bench sampling point inside run cycle 0.
  task automatic start_run();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic watch(input int n, input int done_exp, input int start_at, input int flush_at);
    int   first_done;
    exp_t e;
    first_done = -1;
    for (int c = 0; c < n; c++) begin
      if (valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 64'(valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("valid_cycle", 64'(c), 64'(e.cyc));
          chk("ctrl_vars", 64'(cv), 64'(e.v));
        end
      end
      if (done === 1'b1 && first_done < 0) first_done = c;
      start = (c == start_at);
      flush = (c == flush_at);
      step();
    end
    start = 1'b0;
    flush = 1'b0;
    chk("done_cycle", 64'(first_done), 64'(done_exp));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic push_full_033();
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        push(3 + 4 * j + k, 0, j, k);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; start = 1'b0;
    ext = '0; cf = '0; offset = '0;
    #1;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(sched_err), 64'd0);
    chk("rst_vars", 64'(cv), 64'd0);
    step();
    rst = 1'b0;

    // 16 consecutive valids at cycles 3..18, done from 19
    config_run(pt(1, 4, 4), pt(0, 4, 1), 3);
    push_full_033();
    start_run();
    watch(25, 19, -1, -1);
    chk("held_vars", 64'(cv), 64'(pt(0, 3, 3)));
    chk("done_held", 64'(done), 64'd1);

    // extent 0 acts as 1; start during RUN is ignored
    config_run(pt(1, 2, 0), pt(0, 3, 5), 1);
    push(1, 0, 0, 0);
    push(4, 0, 1, 0);
    start_run();
    watch(8, 5, 2, -1);

    // flush at cycle 7 then replay from the origin
    config_run(pt(1, 4, 4), pt(0, 4, 1), 3);
    for (int k = 0; k < 4; k++) push(3 + k, 0, 0, k);
    push(7, 0, 1, 0);
    start_run();
    watch(20, -1, -1, 7);
    chk("flush_vars", 64'(cv), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    push_full_033();
    start_run();
    watch(25, 19, -1, -1);

    // sparse schedule, restarted from DONE
    config_run(pt(1, 2, 3), pt(0, 10, 2), 0);
    push(0, 0, 0, 0); push(2, 0, 0, 1); push(4, 0, 0, 2);
    push(10, 0, 1, 0); push(12, 0, 1, 1); push(14, 0, 1, 2);
    start_run();
    watch(20, 15, -1, -1);

    // equal targets: second point misses its slot
    config_run(pt(1, 1, 2), pt(0, 0, 0), 0);
    start_run();
    chk("miss_c0_valid", 64'(valid), 64'd1);
    chk("miss_c0_err", 64'(sched_err), 64'd0);
`ifdef AFFINE_LOOP_CTRL_CHECK_EN
    step();
    chk("miss_c1_err", 64'(sched_err), 64'd1);
    chk("miss_c1_valid", 64'(valid), 64'd0);
    chk("miss_c1_done", 64'(done), 64'd0);
    step();
    chk("miss_c2_done", 64'(done), 64'd1);
    chk("miss_c2_err", 64'(sched_err), 64'd1);
    step();
    chk("miss_sticky", 64'(sched_err), 64'd1);
    start_run();
    chk("restart_err", 64'(sched_err), 64'd0);
    chk("restart_valid", 64'(valid), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_err", 64'(sched_err), 64'd0);
    chk("flush_idle", 64'(done), 64'd0);
`else
    for (int c = 1; c < 9; c++) begin
      step();
      chk("nochk_err", 64'(sched_err), 64'd0);
      chk("nochk_done", 64'(done), 64'd0);
      chk("nochk_valid", 64'(valid), 64'd0);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("nochk_flush_vars", 64'(cv), 64'd0);
`endif

    // asynchronous reset mid-run at cycle 5
    config_run(pt(1, 4, 4), pt(0, 4, 1), 3);
    push(3, 0, 0, 0);
    push(4, 0, 0, 1);
    start_run();
    watch(5, -1, -1, -1);
    chk("pre_rst_vars", 64'(cv), 64'(pt(0, 0, 2)));
    chk("pre_rst_valid", 64'(valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_valid", 64'(valid), 64'd0);
    chk("async_vars", 64'(cv), 64'd0);
    chk("async_done", 64'(done), 64'd0);
    chk("async_err", 64'(sched_err), 64'd0);
    start = 1'b1;
    flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_dom_valid", 64'(valid), 64'd0);
      chk("rst_dom_vars", 64'(cv), 64'd0);
      chk("rst_dom_done", 64'(done), 64'd0);
    end
    start = 1'b0;
    flush = 1'b0;
    step();
    rst = 1'b0;
    watch(25, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time bound");
    $fatal(1, "timeout");
  end

endmodule
